ysyx_bus_rd_sched: RTL and testbench

//   Read-channel scheduler that shares one AXI4 master AR/R channel between IFU fetches and LSU loads.
//   It accepts one request at a time and arbitrates with LSU priority plus an IFU anti-starvation counter.
//   It drives single-beat AXI reads, returns lane-aligned 32-bit data and a done pulse to the owner, and

---
 rtl/ysyx_bus_rd_sched.sv | 154 +++++++++++++++
 tb/tb_ysyx_bus_rd_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_bus_rd_sched.sv
// Read-channel scheduler: shares one AXI4 AR/R channel between IFU fetches and LSU loads,
// LSU-first arbitration with IFU anti-starvation, single-beat reads and a read watchdog.
module ysyx_bus_rd_sched #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TO_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_valid,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [2:0]        lsu_size,
  output logic              lsu_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ifu_done,
  output logic              lsu_done,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  localparam int unsigned     SC_W    = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
  localparam logic [TO_W-1:0] WD_ONES = '1;
  localparam logic [TO_W-1:0] WD_LAST = WD_ONES - TO_W'(1);

  state_t            r_state;
  logic              r_owner_lsu;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [TO_W-1:0]   r_wdog;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_ifu_done;
  logic              r_lsu_done;
  logic              r_rsp_err;

  logic              w_starved;
  logic              w_grant_lsu;
  logic              w_grant_ifu;
  logic [2:0]        w_lsu_size;
  logic [31:0]       w_word;
  logic [31:0]       w_shifted;
  logic              w_wd_exp;

  assign w_starved  = (r_starve_cnt == SC_MAX);
  assign w_lsu_size = (lsu_size > 3'd2) ? 3'd2 : lsu_size;
  assign w_word     = r_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
  assign w_shifted  = w_word >> {r_addr[1:0], 3'b000};
  // Expiry is a threshold so a late AR handshake at the last count cannot wrap the counter in R.
  assign w_wd_exp   = (r_wdog >= WD_LAST);

  always_comb begin
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      if (lsu_valid && !(ifu_valid && w_starved)) w_grant_lsu = 1'b1;
      else if (ifu_valid)                         w_grant_ifu = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_lsu  <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_starve_cnt <= '0;
      r_wdog       <= '0;
      r_rsp_data   <= '0;
      r_ifu_done   <= 1'b0;
      r_lsu_done   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_ifu_done <= 1'b0;
      r_lsu_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsu || w_grant_ifu) begin
            r_owner_lsu <= w_grant_lsu;
            r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_size      <= w_grant_lsu ? w_lsu_size : 3'd2;
            r_wdog      <= '0;
            r_state     <= S_AR;
            if (w_grant_ifu)
              r_starve_cnt <= '0;
            else if (ifu_valid && !w_starved)
              r_starve_cnt <= r_starve_cnt + SC_W'(1);
          end
        end
        S_AR: begin
          if (m_arready) begin
            r_state <= S_R;
            if (!w_wd_exp) r_wdog <= r_wdog + TO_W'(1);
          end else if (w_wd_exp) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_ifu_done <= !r_owner_lsu;
            r_lsu_done <= r_owner_lsu;
            r_state    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        S_R: begin
          if (m_rvalid) begin
            r_rsp_data <= DATA_W'(w_shifted);
            r_rsp_err  <= (m_rresp != 2'b00);
            r_ifu_done <= !r_owner_lsu;
            r_lsu_done <= r_owner_lsu;
            r_state    <= S_IDLE;
          end else if (w_wd_exp) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_ifu_done <= !r_owner_lsu;
            r_lsu_done <= r_owner_lsu;
            r_state    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifu_ready = w_grant_ifu;
  assign lsu_ready = w_grant_lsu;
  assign rsp_data  = r_rsp_data;
  assign ifu_done  = r_ifu_done;
  assign lsu_done  = r_lsu_done;
  assign rsp_err   = r_rsp_err;
  assign m_araddr  = r_addr;
  assign m_arsize  = r_size;
  assign m_arvalid = (r_state == S_AR);
  assign m_rready  = (r_state == S_R);

endmodule

// File: tb/tb_ysyx_bus_rd_sched.sv
// Scoreboard bench for ysyx_bus_rd_sched: directed requests push expected grants/completions,
// a negedge monitor pops and compares them; a small AXI slave model answers the reads.
module tb_ysyx_bus_rd_sched;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_addr;
  logic        ifu_ready;
  logic        lsu_valid;
  logic [31:0] lsu_addr;
  logic [2:0]  lsu_size;
  logic        lsu_ready;
  logic [31:0] rsp_data;
  logic        ifu_done;
  logic        lsu_done;
  logic        rsp_err;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic        m_arvalid;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  ysyx_bus_rd_sched #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TO_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ifu_valid(ifu_valid),
    .ifu_addr (ifu_addr),
    .ifu_ready(ifu_ready),
    .lsu_valid(lsu_valid),
    .lsu_addr (lsu_addr),
    .lsu_size (lsu_size),
    .lsu_ready(lsu_ready),
    .rsp_data (rsp_data),
    .ifu_done (ifu_done),
    .lsu_done (lsu_done),
    .rsp_err  (rsp_err),
    .m_araddr (m_araddr),
    .m_arsize (m_arsize),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    bit          err;
    int          lat;
  } txn_t;

  txn_t  exp_q[$];
  txn_t  cur;
  bit    cur_v;
  int    cyc;
  int    rdy_cyc;
  int    n_pass;
  int    n_total;

  int          ar_delay;
  bit          r_en;
  bit          stray;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_rresp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // AXI slave model: decisions taken at negedge, handshakes land on the next posedge.
  initial begin : slave
    int ar_cnt;
    ar_cnt    = 0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    forever begin
      @(negedge clk);
      if (m_arvalid) begin
        m_arready = (ar_cnt >= ar_delay);
        ar_cnt++;
      end else begin
        m_arready = 1'b0;
        ar_cnt    = 0;
      end
      m_rvalid = (m_rready && r_en) || stray;
      m_rdata  = slv_rdata;
      m_rresp  = slv_rresp;
    end
  end

  // Monitor: completions first (same-cycle regrant allowed), then grants, then AR stability.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cur_v = 1'b0;
    end else begin
      if (ifu_done || lsu_done) begin
        chk("done_has_owner", 64'(cur_v), 64'd1);
        if (cur_v) begin
          chk("done_owner", {62'd0, ifu_done, lsu_done}, cur.lsu ? 64'd1 : 64'd2);
          chk("rsp_data", 64'(rsp_data), 64'(cur.data));
          chk("rsp_err", 64'(rsp_err), 64'(cur.err));
          if (cur.lat > 0) chk("latency", 64'(cyc - rdy_cyc), 64'(cur.lat));
          cur_v = 1'b0;
        end
      end
      if (ifu_ready || lsu_ready) begin
        chk("ready_expected", 64'(exp_q.size() != 0), 64'd1);
        chk("ready_not_busy", 64'(cur_v), 64'd0);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("grant_owner", {62'd0, ifu_ready, lsu_ready}, cur.lsu ? 64'd1 : 64'd2);
          cur_v   = 1'b1;
          rdy_cyc = cyc;
        end
      end
      if (m_arvalid) begin
        chk("arvalid_owned", 64'(cur_v), 64'd1);
        if (cur_v) begin
          chk("araddr", 64'(m_araddr), 64'(cur.addr));
          chk("arsize", 64'(m_arsize), 64'(cur.size));
        end
      end
    end
  end

  task automatic push(input bit lsu, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] data, input bit err, input int lat);
    txn_t t;
    t.lsu = lsu; t.addr = addr; t.size = size; t.data = data; t.err = err; t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic req(input bit lsu, input logic [31:0] addr, input logic [2:0] sz,
                     input logic [2:0] exp_size, input logic [31:0] data, input bit err,
                     input int lat);
    bit seen;
    seen = 1'b0;
    push(lsu, addr, exp_size, data, err, lat);
    if (lsu) begin lsu_valid = 1'b1; lsu_addr = addr; lsu_size = sz; end
    else     begin ifu_valid = 1'b1; ifu_addr = addr; end
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = lsu ? lsu_ready : ifu_ready;
    end
    chk("ready_within_budget", 64'(seen), 64'd1);
    @(posedge clk); #1;
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cur_v || exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("complete_within_budget", 64'(cur_v || exp_q.size() != 0), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ifu_ready"}, 64'(ifu_ready), 64'd0);
    chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'd0);
    chk({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    chk({tag, "_done"},      {62'd0, ifu_done, lsu_done}, 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_araddr"},    64'(m_araddr),  64'd0);
    chk({tag, "_arsize"},    64'(m_arsize),  64'd0);
    chk({tag, "_arvalid"},   64'(m_arvalid), 64'd0);
    chk({tag, "_rready"},    64'(m_rready),  64'd0);
  endtask

  initial begin : stim
    int  grants;
    bit  in_r;
    n_pass = 0; n_total = 0; cyc = 0; cur_v = 1'b0; rdy_cyc = 0;
    rst = 1'b1; ifu_valid = 1'b0; ifu_addr = '0; lsu_valid = 1'b0; lsu_addr = '0; lsu_size = '0;
    ar_delay = 0; r_en = 1'b1; stray = 1'b0; slv_rdata = '0; slv_rresp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Basic fetch from the upper lane, minimum latency.
    slv_rdata = 64'h11223344_55667788;
    req(1'b0, 32'h8000_0004, 3'd0, 3'd2, 32'h1122_3344, 1'b0, 3);
    wait_idle();

    // Byte load at offset 3 of the lower lane.
    slv_rdata = 64'h99999999_AABBCCDD;
    req(1'b1, 32'h8000_0003, 3'd0, 3'd0, 32'h0000_00AA, 1'b0, 3);
    wait_idle();

    // Oversized size code clamps to word; SLVERR flags the response but data still returns.
    slv_rresp = 2'b10;
    req(1'b1, 32'h0000_0012, 3'd7, 3'd2, 32'h0000_AABB, 1'b1, 3);
    wait_idle();
    slv_rresp = 2'b00;

    // Both requesters held: L,L,L,L,I twice.
    slv_rdata = 64'h01234567_89ABCDEF;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) push(1'b0, 32'h0000_1000, 3'd2, 32'h89AB_CDEF, 1'b0, 3);
      else              push(1'b1, 32'h0000_2006, 3'd1, 32'h0000_0123, 1'b0, 3);
    end
    ifu_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_valid = 1'b1; lsu_addr = 32'h0000_2006; lsu_size = 3'd1;
    grants = 0;
    for (int n = 0; n < 300 && grants < 10; n++) begin
      @(negedge clk);
      if (ifu_ready || lsu_ready) grants++;
    end
    chk("starve_grants", 64'(grants), 64'd10);
    @(posedge clk); #1;
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    wait_idle();

    // AR stalled for 5 cycles; monitor checks address/size stability every AR cycle.
    ar_delay = 5;
    req(1'b0, 32'h0000_3008, 3'd0, 3'd2, 32'h89AB_CDEF, 1'b0, 8);
    wait_idle();
    ar_delay = 0;

    // No R beat: watchdog completes with error after 7 cycles in AR/R.
    r_en = 1'b0;
    req(1'b1, 32'h0000_4000, 3'd2, 3'd2, 32'h0000_0000, 1'b1, 8);
    wait_idle();
    stray = 1'b1;
    @(negedge clk);
    chk("stray_rready_low", 64'(m_rready), 64'd0);
    @(posedge clk); #1 stray = 1'b0;
    repeat (3) @(posedge clk);
    #1 r_en = 1'b1;
    req(1'b1, 32'h0000_4004, 3'd2, 3'd2, 32'h0123_4567, 1'b0, 3);
    wait_idle();

    // Reset while in R: abandoned without a done, then a clean request.
    r_en = 1'b0;
    req(1'b0, 32'h0000_5000, 3'd0, 3'd2, 32'h0000_0000, 1'b0, 0);
    in_r = 1'b0;
    for (int n = 0; n < 50 && !in_r; n++) begin
      @(negedge clk);
      in_r = m_rready;
    end
    chk("reached_r", 64'(in_r), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1 rst = 1'b0;
    r_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req(1'b0, 32'h0000_5004, 3'd0, 3'd2, 32'h0123_4567, 1'b0, 3);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
